// File: rtl/drfm_mm_playback.sv
// DRFM playback: reads recorded words over Avalon-MM into a prefetch FIFO and emits scaled samples on each DAC strobe.
// Define DRFM_PLAYBACK_LOOP_EN for circular playback until Stop; otherwise Length words play once and the block drains itself.
module drfm_mm_playback #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stop,
    input  logic [24:0] Length,
    input  logic [9:0]  Delay,
    input  logic [3:0]  Scale,
    output logic        Avalon_ChipEnable,
    output logic [24:0] Avalon_Address,
    output logic [1:0]  Avalon_ByteEnable,
    output logic        Avalon_Read,
    input  logic        Avalon_WaitRequest,
    input  logic [15:0] Avalon_ReadData,
    input  logic        Avalon_ReadDataValid,
    input  logic        Sample_Strobe,
    output logic [15:0] Sample_Out,
    output logic        Sample_Valid,
    output logic        Underflow,
    output logic        Busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, PREFILL, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [24:0]   len_q, len_d;
    logic [24:0]   addr_q, addr_d;
    logic [24:0]   issued_q, issued_d;
    logic [3:0]    scale_q, scale_d;
    logic          read_q, read_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          underflow_q, underflow_d;
    logic [15:0]   fifo_mem [FIFO_DEPTH];

    logic          accept, ret, push, pop, more_reads, all_in, finished, hold_rd;
    logic signed [15:0] head_word;
    logic [CW:0]   level_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        issued_d    = issued_q;
        scale_d     = scale_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        underflow_d = underflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push        = 1'b0;
        pop         = 1'b0;
        head_word   = fifo_mem[rd_ptr_q];

        hold_rd = read_q && Avalon_WaitRequest;
        accept  = read_q && !Avalon_WaitRequest;
        // A zero outstanding count means the data belongs to a read issued before reset.
        ret     = Avalon_ReadDataValid && (outst_q != '0);

        if (accept) begin
            addr_d   = (addr_q == len_q - 25'd1) ? 25'd0 : addr_q + 25'd1;
            issued_d = issued_q + 25'd1;
        end
        outst_d = outst_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, ret};

`ifdef DRFM_PLAYBACK_LOOP_EN
        all_in   = 1'b0;
        finished = 1'b0;
`else
        all_in   = (issued_d == len_q) && (outst_d == '0);
        finished = (issued_q == len_q) && (outst_q == '0) && (cnt_q == '0);
`endif

        if (state_q == PREFILL || state_q == RUN)
            push = ret;

        if (state_q == RUN && Sample_Strobe && !finished) begin
            valid_d = 1'b1;
            if (cnt_q != '0) begin
                pop      = 1'b1;
                sample_d = head_word >>> scale_q;
            end else begin
                sample_d    = 16'd0;
                underflow_d = 1'b1;
            end
        end

        cnt_d = cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case (state_q)
            IDLE: begin
                if (Start && Length != 25'd0) begin
                    state_d     = PREFILL;
                    len_d       = Length;
                    scale_d     = Scale;
                    addr_d      = {15'd0, Delay} % Length;
                    issued_d    = 25'd0;
                    underflow_d = 1'b0;
                    cnt_d       = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                end
            end
            PREFILL: begin
                if (Stop)
                    state_d = DRAIN;
                else if (cnt_d == CW'(FIFO_DEPTH) || all_in)
                    state_d = RUN;
            end
            RUN: begin
                if (Stop || finished)
                    state_d = DRAIN;
            end
            default: begin
                cnt_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                if (outst_d == '0 && !hold_rd)
                    state_d = IDLE;
            end
        endcase

`ifdef DRFM_PLAYBACK_LOOP_EN
        more_reads = 1'b1;
`else
        more_reads = (issued_d < len_d);
`endif
        level_d = {1'b0, cnt_d} + {1'b0, outst_d};
        if (hold_rd)
            read_d = 1'b1;
        else
            read_d = (state_d == PREFILL || state_d == RUN) && more_reads
                     && (level_d < (CW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge Clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= Avalon_ReadData;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            len_q       <= 25'd0;
            addr_q      <= 25'd0;
            issued_q    <= 25'd0;
            scale_q     <= 4'd0;
            read_q      <= 1'b0;
            cnt_q       <= '0;
            outst_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sample_q    <= 16'd0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            scale_q     <= scale_d;
            read_q      <= read_d;
            cnt_q       <= cnt_d;
            outst_q     <= outst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign Avalon_ChipEnable = 1'b1;
    assign Avalon_ByteEnable = 2'b11;
    assign Avalon_Address    = addr_q;
    assign Avalon_Read       = read_q;
    assign Sample_Out        = sample_q;
    assign Sample_Valid      = valid_q;
    assign Underflow         = underflow_q;
    assign Busy              = (state_q != IDLE);
endmodule

// File: doc/drfm_mm_playback.md
DRFM_MM_PLAYBACK -- requirements
Module: drfm_mm_playback

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, read-data buffer depth in 16-bit words (power of two, 4..64).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: single-cycle request to begin playback.
REQ-005 SHALL have port Stop, input, 1 bit: single-cycle request to end playback.
REQ-006 SHALL have port Length, input, 25 bits: number of recorded words.
REQ-007 SHALL have port Delay, input, 10 bits: start word offset.
REQ-008 SHALL have port Scale, input, 4 bits: arithmetic right-shift amount.
REQ-009 SHALL have Avalon read-master ports: Avalon_ChipEnable out 1; Avalon_Address out 25; Avalon_ByteEnable out 2; Avalon_Read out 1; Avalon_WaitRequest in 1; Avalon_ReadData in 16; Avalon_ReadDataValid in 1.
REQ-010 SHALL have port Sample_Strobe, input, 1 bit: DAC sample-rate tick.
REQ-011 SHALL have port Sample_Out, output, 16 bits: scaled sample.
REQ-012 SHALL have port Sample_Valid, output, 1 bit: one-cycle pulse marking a new Sample_Out.
REQ-013 SHALL have port Underflow, output, 1 bit: sticky buffer-starvation flag.
REQ-014 SHALL have port Busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL drive Avalon_ChipEnable=1 and Avalon_ByteEnable=2'b11 constantly.
REQ-016 SHALL implement states IDLE, PREFILL, RUN, DRAIN.
REQ-017 IDLE: on Start with Length!=0, SHALL latch Length, Scale, and start address = Delay mod Length, clear Underflow, and enter PREFILL; Start with Length==0 SHALL be ignored.
REQ-018 SHALL assert Avalon_Read in PREFILL/RUN only while (FIFO occupancy + outstanding reads) < FIFO_DEPTH, and SHALL hold Avalon_Address and Avalon_Read stable while Avalon_WaitRequest=1.
REQ-019 A read SHALL be accepted on the cycle Avalon_Read=1 and Avalon_WaitRequest=0; the address then SHALL increment, becoming 0 after Length-1.
REQ-020 SHALL push Avalon_ReadData into the FIFO on every Avalon_ReadDataValid; the outstanding count SHALL decrement on that cycle, and simultaneous accept and return SHALL leave it unchanged.
REQ-021 PREFILL SHALL move to RUN on the cycle the FIFO becomes full.
REQ-022 RUN: on Sample_Strobe with FIFO non-empty, SHALL pop one word and, the next cycle, present Sample_Out = word >>> Scale (sign-extended) with Sample_Valid=1 for one cycle.
REQ-023 RUN: on Sample_Strobe with FIFO empty, SHALL present Sample_Out=0 with Sample_Valid=1 next cycle and set Underflow.
REQ-024 In RUN, a push and a pop in the same cycle SHALL leave occupancy unchanged; a push into a full FIFO SHALL never occur, by construction of REQ-018.
REQ-025 Stop in PREFILL/RUN SHALL deassert Avalon_Read (after any pending WaitRequest handshake completes) and enter DRAIN.
REQ-026 DRAIN SHALL discard returning data, flush the FIFO, ignore Sample_Strobe, and enter IDLE when outstanding reads = 0.
REQ-027 Start outside IDLE SHALL be ignored; Stop in IDLE or DRAIN SHALL be ignored; Stop and Start in the same IDLE cycle: Start wins.

Reset
REQ-028 Reset SHALL asynchronously force state=IDLE; Avalon_Read=0, Avalon_Address=0, Sample_Out=0, Sample_Valid=0, Underflow=0, Busy=0; FIFO empty; outstanding count 0.
REQ-029 Read data returning after a mid-operation reset SHALL be discarded while the outstanding count is 0.

Configuration
REQ-030 With macro DRFM_PLAYBACK_LOOP_EN defined, RUN SHALL play circularly indefinitely per REQ-019 until Stop.
REQ-031 Without DRFM_PLAYBACK_LOOP_EN, after Length accepted reads SHALL stop issuing reads, play out the remaining FIFO contents, then enter DRAIN automatically once the FIFO is empty.

Verification
REQ-032 Length=8, Delay=3, Scale=0, memory word n = n: Start -> addresses 3,4,5,6,7,0,1,2,3...; Sample_Out sequence 3,4,5,6,7,0,1,...
REQ-033 Word 0x8000, Scale=4 -> Sample_Out=0xF800; word 0x7FF0, Scale=4 -> 0x07FF.
REQ-034 WaitRequest held high for 5 cycles mid-run -> Address/Read stable throughout; no lost or duplicated word.
REQ-035 Memory read latency raised to 40 cycles with strobe every cycle, FIFO_DEPTH=16 -> Underflow=1; zero samples output; recovery resumes the sequence.
REQ-036 Stop with 3 reads outstanding -> DRAIN; Busy falls exactly after the third ReadDataValid; Sample_Valid stays 0.
REQ-037 Reset asserted during RUN with reads outstanding -> all outputs reach reset values immediately; late ReadDataValid ignored; next Start plays correctly.
